// File: rtl/rangefinder_sample_capture_pkg.sv
// Shared types and constants for the rangefinder sample capture block.
package rangefinder_capture_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_DECIM_W = 4;

    // Trigger source selection
    localparam logic TRIG_EXT = 1'b0;
    localparam logic TRIG_THR = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/rangefinder_sample_capture_if.sv
// Control, ADC and RAM port-2 signals of the capture block, bundled as one interface.
interface rangefinder_sample_capture_if import rangefinder_capture_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DECIM_W = DEF_DECIM_W
);
    logic                arm;
    logic                abort;
    logic                trig_sel;
    logic                ext_trig;
    logic [DATA_W-1:0]   threshold;
    logic [DECIM_W-1:0]  decim;
    logic [DATA_W-1:0]   adc_data;
    logic                adc_valid;
    logic [ADDR_W-1:0]   address2;
    logic                chipselect2;
    logic                write2;
    logic [DATA_W-1:0]   writedata2;
    logic                busy;
    logic                done;
    logic [ADDR_W:0]     count;

    // Capture engine side: consumes control/ADC, drives RAM port 2 and status
    modport master (
        input  arm, abort, trig_sel, ext_trig, threshold, decim, adc_data, adc_valid,
        output address2, chipselect2, write2, writedata2, busy, done, count
    );

    // CPU / ADC / RAM side
    modport slave (
        output arm, abort, trig_sel, ext_trig, threshold, decim, adc_data, adc_valid,
        input  address2, chipselect2, write2, writedata2, busy, done, count
    );
endinterface

// File: rtl/rangefinder_trig_detect.sv
// Trigger detector: external strobe rising edge or upward threshold crossing.
module rangefinder_trig_detect import rangefinder_capture_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig_sel_i,
    input  logic              ext_trig_i,
    input  logic [DATA_W-1:0] threshold_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              adc_valid_i,
    input  logic              armed_i,
    input  logic              arm_start_i,
    output logic              trig_event_o
);
    logic              ext_prev_q;
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;
    logic              ext_evt;
    logic              thr_evt;

    // Track last strobe level and last valid sample; arming forgets the old sample
    // so the first sample after arm can never be a crossing
    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_prev_q   <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            ext_prev_q <= ext_trig_i;
            if (arm_start_i) begin
                prev_valid_q <= 1'b0;
            end else if (adc_valid_i) begin
                prev_q       <= adc_data_i;
                prev_valid_q <= 1'b1;
            end
        end
    end

    assign ext_evt = ext_trig_i & ~ext_prev_q;
    assign thr_evt = adc_valid_i & prev_valid_q & (prev_q < threshold_i) & (adc_data_i >= threshold_i);
    assign trig_event_o = armed_i & ((trig_sel_i == TRIG_EXT) ? ext_evt : thr_evt);

endmodule

// File: rtl/rangefinder_sample_capture.sv
// Burst capture engine: arm, wait for trigger, write decimated samples to RAM port 2.
module rangefinder_sample_capture import rangefinder_capture_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DECIM_W = DEF_DECIM_W
) (
    input  logic clk,
    input  logic reset,
    rangefinder_sample_capture_if.master bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               done_q, done_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic trig_event;
    logic arm_start;
    logic sample_valid;
    logic accept;

    rangefinder_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk          (clk),
        .reset        (reset),
        .trig_sel_i   (bus.trig_sel),
        .ext_trig_i   (bus.ext_trig),
        .threshold_i  (bus.threshold),
        .adc_data_i   (bus.adc_data),
        .adc_valid_i  (bus.adc_valid),
        .armed_i      (state_q == ARMED),
        .arm_start_i  (arm_start),
        .trig_event_o (trig_event)
    );

    // Abort always wins over arm; the trigger-cycle sample counts as capture sample 0
    assign arm_start    = (state_q == IDLE) && bus.arm && !bus.abort;
    assign sample_valid = bus.adc_valid && !bus.abort && (count_q != DEPTH_C) &&
                          ((state_q == CAPTURE) || ((state_q == ARMED) && trig_event));
    assign accept       = sample_valid && (dcnt_q == '0);

    // Next-state logic for the FSM, decimation counter and one-deep write stage
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        done_d  = done_q;
        decim_d = decim_q;
        dcnt_d  = dcnt_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_d = ARMED;
                        done_d  = 1'b0;
                        count_d = '0;
                        ptr_d   = '0;
                        decim_d = bus.decim;
                        dcnt_d  = '0;
                    end
                end
                ARMED: begin
                    if (trig_event) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (count_q == DEPTH_C) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (sample_valid) begin
            dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
        end

        if (accept) begin
            wr_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = bus.adc_data;
            count_d = count_q + 1'b1;
            ptr_d   = ((count_q + 1'b1) == DEPTH_C) ? '0 : ptr_q + 1'b1;
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            decim_q <= '0;
            dcnt_q  <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
            decim_q <= decim_d;
            dcnt_q  <= dcnt_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.address2    = waddr_q;
    assign bus.chipselect2 = wr_q;
    assign bus.write2      = wr_q;
    assign bus.writedata2  = wdata_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
// Bench for the sample capture block: directed scenarios plus random traffic,
// all checked each cycle against a burst-level reference model.
`timescale 1ns/1ps
module tb_rangefinder_sample_capture;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset;

    int testsRun    = 0;
    int testsFailed = 0;

    rangefinder_sample_capture_if #(.DATA_W(8), .ADDR_W(8), .DECIM_W(4)) bus ();

    rangefinder_sample_capture dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: phase 0 idle, 1 waiting for trigger, 2 capturing
    int        mPhase = 0;
    int        mCount = 0;
    int        mDone  = 0;
    int        mDecim = 0;
    int        mSeen  = 0;
    int        mWr    = 0;
    int        mAddr  = 0;
    int        mData  = 0;
    int        mPrev  = 0;
    int        mHavePrev = 0;
    int        mExtPrev  = 0;

    logic [7:0] ramImg [0:255];
    int         wrTotal = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelStep();
        int cntBefore;
        bit edgeEv, thrEv, trig;
        if (!reset) begin
            mPhase = 0; mCount = 0; mDone = 0; mDecim = 0; mSeen = 0;
            mWr = 0; mAddr = 0; mData = 0; mPrev = 0; mHavePrev = 0; mExtPrev = 0;
            return;
        end
        cntBefore = mCount;
        edgeEv = bus.ext_trig && (mExtPrev == 0);
        thrEv  = bus.adc_valid && (mHavePrev != 0) && (mPrev < int'(bus.threshold)) &&
                 (int'(bus.adc_data) >= int'(bus.threshold));
        trig   = (mPhase == 1) && (bus.trig_sel ? thrEv : edgeEv);

        mWr = 0;
        if (!bus.abort && bus.adc_valid && cntBefore < DEPTH && (mPhase == 2 || trig)) begin
            if (mSeen % (mDecim + 1) == 0) begin
                mWr    = 1;
                mAddr  = cntBefore;
                mData  = int'(bus.adc_data);
                mCount = cntBefore + 1;
            end
            mSeen++;
        end

        if (mPhase == 0 && bus.arm && !bus.abort) mHavePrev = 0;
        else if (bus.adc_valid) begin
            mPrev     = int'(bus.adc_data);
            mHavePrev = 1;
        end
        mExtPrev = int'(bus.ext_trig);

        if (bus.abort) mPhase = 0;
        else begin
            case (mPhase)
                0: if (bus.arm) begin
                       mPhase = 1; mDone = 0; mCount = 0; mDecim = int'(bus.decim); mSeen = 0;
                   end
                1: if (trig) mPhase = 2;
                2: if (cntBefore == DEPTH) begin mPhase = 0; mDone = 1; end
                default: mPhase = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Compare DUT outputs against the model every cycle, and keep a RAM image
    initial forever begin
        @(negedge clk);
        checkOutput("busy", 32'(bus.busy), 32'(mPhase != 0));
        checkOutput("done", 32'(bus.done), 32'(mDone));
        checkOutput("count", 32'(bus.count), 32'(mCount));
        checkOutput("write2", 32'(bus.write2), 32'(mWr));
        checkOutput("chipselect2", 32'(bus.chipselect2), 32'(mWr));
        if (mWr != 0) begin
            checkOutput("address2", 32'(bus.address2), 32'(mAddr));
            checkOutput("writedata2", 32'(bus.writedata2), 32'(mData));
        end
        if (bus.write2) begin
            ramImg[bus.address2] = bus.writedata2;
            wrTotal++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic arm, input logic abort, input logic ext,
                                 input logic valid, input logic [7:0] data);
        bus.arm       = arm;
        bus.abort     = abort;
        bus.ext_trig  = ext;
        bus.adc_valid = valid;
        bus.adc_data  = data;
        tick();
    endtask

    initial begin
        int errs;
        int wrBase;

        reset         = 1'b0;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.trig_sel  = 1'b0;
        bus.ext_trig  = 1'b0;
        bus.threshold = 8'h00;
        bus.decim     = 4'd0;
        bus.adc_data  = 8'hA5;
        bus.adc_valid = 1'b1;

        // Reset held low with valid samples present
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset count", 32'(bus.count), 0);
        checkOutput("reset write2", 32'(bus.write2), 0);
        checkOutput("reset chipselect2", 32'(bus.chipselect2), 0);
        checkOutput("reset address2", 32'(bus.address2), 0);
        checkOutput("reset writedata2", 32'(bus.writedata2), 0);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 8'h00);

        // Full burst on external trigger, no decimation
        bus.trig_sel = 1'b0;
        bus.decim    = 4'd0;
        applyStimulus(1, 0, 0, 0, 8'h00);
        wrBase = wrTotal;
        for (int k = 0; k < 256; k++) applyStimulus(0, 0, 1, 1, 8'(k));
        bus.adc_valid = 1'b0;
        bus.ext_trig  = 1'b0;
        @(negedge clk);
        checkOutput("ext last write2", 32'(bus.write2), 1);
        checkOutput("ext last address2", 32'(bus.address2), 32'hFF);
        checkOutput("ext last data", 32'(bus.writedata2), 32'hFF);
        checkOutput("ext last count", 32'(bus.count), 256);
        checkOutput("ext done early", 32'(bus.done), 0);
        tick();
        @(negedge clk);
        checkOutput("ext done", 32'(bus.done), 1);
        checkOutput("ext busy", 32'(bus.busy), 0);
        checkOutput("ext count", 32'(bus.count), 256);
        checkOutput("ext no extra write", 32'(bus.write2), 0);
        errs = 0;
        for (int i = 0; i < 256; i++) if (ramImg[i] !== 8'(i)) errs++;
        checkOutput("ext ram image errors", 32'(errs), 0);
        checkOutput("ext write total", 32'(wrTotal - wrBase), 256);

        // Threshold crossing on a rising ramp
        bus.trig_sel  = 1'b1;
        bus.threshold = 8'h80;
        applyStimulus(1, 0, 0, 1, 8'h10);
        applyStimulus(0, 0, 0, 1, 8'h70);
        applyStimulus(0, 0, 0, 1, 8'h7F);
        applyStimulus(0, 0, 0, 1, 8'h80);
        bus.adc_data = 8'h81;
        @(negedge clk);
        checkOutput("thr first write2", 32'(bus.write2), 1);
        checkOutput("thr first address", 32'(bus.address2), 0);
        checkOutput("thr first data", 32'(bus.writedata2), 32'h80);
        tick();
        applyStimulus(0, 1, 0, 0, 8'h00);
        bus.abort = 1'b0;
        @(negedge clk);
        checkOutput("thr abort count", 32'(bus.count), 2);
        checkOutput("thr abort busy", 32'(bus.busy), 0);

        // Data already above threshold after arm must drop and recross
        applyStimulus(1, 0, 0, 1, 8'h10);
        applyStimulus(0, 0, 0, 1, 8'h90);
        applyStimulus(0, 0, 0, 1, 8'h91);
        applyStimulus(0, 0, 0, 1, 8'h50);
        @(negedge clk);
        checkOutput("thr high no trigger count", 32'(bus.count), 0);
        checkOutput("thr high still armed", 32'(bus.busy), 1);
        applyStimulus(0, 0, 0, 1, 8'h85);
        bus.adc_valid = 1'b0;
        @(negedge clk);
        checkOutput("thr recross data", 32'(bus.writedata2), 32'h85);
        applyStimulus(0, 1, 0, 0, 8'h00);

        // Decimation by 4
        bus.trig_sel = 1'b0;
        bus.decim    = 4'd3;
        applyStimulus(1, 0, 0, 0, 8'h00);
        wrBase = wrTotal;
        for (int k = 0; k < 20; k++) applyStimulus(0, 0, 1, 1, 8'(16 + k));
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        @(negedge clk);
        checkOutput("decim count", 32'(bus.count), 5);
        errs = 0;
        for (int i = 0; i < 5; i++) if (ramImg[i] !== 8'(16 + 4 * i)) errs++;
        checkOutput("decim ram errors", 32'(errs), 0);
        checkOutput("decim write total", 32'(wrTotal - wrBase), 5);
        applyStimulus(0, 1, 0, 0, 8'h00);

        // Abort after ten accepted samples
        bus.decim = 4'd0;
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 1, 1, 8'(k));
        applyStimulus(0, 1, 1, 1, 8'd10);
        bus.abort     = 1'b0;
        bus.adc_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort count", 32'(bus.count), 10);
        checkOutput("abort done", 32'(bus.done), 0);
        checkOutput("abort busy", 32'(bus.busy), 0);
        applyStimulus(1, 0, 0, 0, 8'h00);
        @(negedge clk);
        checkOutput("rearm count", 32'(bus.count), 0);
        checkOutput("rearm busy", 32'(bus.busy), 1);

        // Simultaneous arm and abort from idle
        applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(1, 1, 0, 0, 8'h00);
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        checkOutput("arm+abort busy", 32'(bus.busy), 0);

        // Arm pulse during capture is ignored
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 1, 8'(k));
        applyStimulus(1, 0, 1, 1, 8'd5);
        applyStimulus(0, 0, 1, 1, 8'd6);
        applyStimulus(0, 0, 1, 1, 8'd7);
        applyStimulus(0, 0, 1, 0, 8'h00);
        @(negedge clk);
        checkOutput("arm in capture count", 32'(bus.count), 8);
        checkOutput("arm in capture busy", 32'(bus.busy), 1);
        applyStimulus(0, 1, 0, 0, 8'h00);

        // Random traffic
        for (int c = 0; c < 5000; c++) begin
            bus.arm   = ($urandom_range(0, 29) == 0);
            bus.abort = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 15) == 0) bus.ext_trig = ~bus.ext_trig;
            bus.adc_valid = ($urandom_range(0, 3) != 0);
            bus.adc_data  = 8'($urandom);
            if (bus.arm) begin
                bus.trig_sel  = 1'($urandom);
                bus.decim     = 4'($urandom_range(0, 3));
                bus.threshold = 8'($urandom);
            end
            tick();
        end

        // Final abort, bounded wait for idle
        applyStimulus(0, 1, 0, 0, 8'h00);
        bus.abort = 1'b0;
        for (int w = 0; w < 5 && bus.busy; w++) tick();
        @(negedge clk);
        checkOutput("final idle", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
